// File: rtl/adder52_17_arbiter.sv
// adder52_17_arbiter
// Shares one A + zero-extended B adder between two requesters with round-robin
// arbitration. There is a single registered result slot. The slot returns its
// result only to the requester that owns it.
module adder52_17_arbiter #(
    parameter int A_W = 52,
    parameter int B_W = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [A_W-1:0]   req0_a,
    input  logic [B_W-1:0]   req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [A_W-1:0]   req1_a,
    input  logic [B_W-1:0]   req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [A_W:0]     rsp0_sum,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [A_W:0]     rsp1_sum,
    output logic             busy
);

    localparam int SUM_W = A_W + 1;

    // Unsigned add. B is zero-extended and the carry-out lands in the top bit.
    function automatic logic [SUM_W-1:0] add_ab(
        input logic [A_W-1:0] a,
        input logic [B_W-1:0] b
    );
        add_ab = {1'b0, a} + {{(SUM_W-B_W){1'b0}}, b};
    endfunction

    // Slot state. The per-owner valid bits encode EMPTY / FULL(0) / FULL(1).
    logic             rsp0_valid_r;
    logic             rsp1_valid_r;
    logic [SUM_W-1:0] rsp0_sum_r;
    logic [SUM_W-1:0] rsp1_sum_r;
    logic             busy_r;
    logic             last_grant_r;

    logic             drain_s;
    logic             can_accept_s;
    logic             grant_valid_s;
    logic             grant_s;
    logic             accept_s;
    logic [A_W-1:0]   sel_a_s;
    logic [B_W-1:0]   sel_b_s;
    logic [SUM_W-1:0] sum_s;

    // The owner takes the result this cycle, so the slot can be refilled with no bubble.
    assign drain_s      = (rsp0_valid_r & rsp0_ready) | (rsp1_valid_r & rsp1_ready);
    assign can_accept_s = ~busy_r | drain_s;

    // Round-robin pick. On contention, the requester not granted last time wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b1;
            end
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_s       = ~last_grant_r;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_s       = 1'b0;
            end
        endcase
    end

    assign accept_s   = can_accept_s & grant_valid_s;
    assign req0_ready = accept_s & ~grant_s;
    assign req1_ready = accept_s & grant_s;

    // Route the winning requester's operands into the single shared adder.
    always_comb begin
        sel_a_s = {A_W{1'b0}};
        sel_b_s = {B_W{1'b0}};
        if (grant_s) begin
            sel_a_s = req1_a;
            sel_b_s = req1_b;
        end else begin
            sel_a_s = req0_a;
            sel_b_s = req0_b;
        end
    end

    assign sum_s = add_ab(sel_a_s, sel_b_s);

    // Result slot. Load on accept, clear on drain, otherwise hold for a stalled owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_sum_r   <= {SUM_W{1'b0}};
            rsp1_sum_r   <= {SUM_W{1'b0}};
            busy_r       <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            rsp0_valid_r <= ~grant_s;
            rsp1_valid_r <= grant_s;
            rsp0_sum_r   <= grant_s ? {SUM_W{1'b0}} : sum_s;
            rsp1_sum_r   <= grant_s ? sum_s : {SUM_W{1'b0}};
            busy_r       <= 1'b1;
            last_grant_r <= grant_s;
        end else if (drain_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_sum_r   <= {SUM_W{1'b0}};
            rsp1_sum_r   <= {SUM_W{1'b0}};
            busy_r       <= 1'b0;
            last_grant_r <= last_grant_r;
        end else begin
            rsp0_valid_r <= rsp0_valid_r;
            rsp1_valid_r <= rsp1_valid_r;
            rsp0_sum_r   <= rsp0_sum_r;
            rsp1_sum_r   <= rsp1_sum_r;
            busy_r       <= busy_r;
            last_grant_r <= last_grant_r;
        end
    end

    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_sum   = rsp0_sum_r;
    assign rsp1_sum   = rsp1_sum_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_adder52_17_arbiter.sv
// Testbench for adder52_17_arbiter. The stimulus pushes expected responses into
// a scoreboard queue. A negedge monitor pops that queue and compares entries
// against the DUT responses.
module tb_adder52_17_arbiter;

    localparam int A_W   = 52;
    localparam int B_W   = 35;
    localparam int SUM_W = 53;

    typedef struct packed {
        logic             owner;
        logic [SUM_W-1:0] sum;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [A_W-1:0]   req0_a, req1_a;
    logic [B_W-1:0]   req0_b, req1_b;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [SUM_W-1:0] rsp0_sum, rsp1_sum;
    logic             busy;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    localparam logic [A_W-1:0]   A_ONES  = 52'hF_FFFF_FFFF_FFFF;
    localparam logic [B_W-1:0]   B_ONES  = 35'h7_FFFF_FFFF;
    localparam logic [A_W-1:0]   A_HI    = 52'h8_0000_0000_0000;
    localparam logic [B_W-1:0]   B_HI    = 35'h4_0000_0000;
    localparam logic [SUM_W-1:0] S_HI    = 53'h08_0004_0000_0000;

    adder52_17_arbiter #(.A_W(A_W), .B_W(B_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_sum   (rsp0_sum),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_sum   (rsp1_sum),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive one cycle of inputs and optionally check the ready pair.
    // Any handshake pushes its expected result.
    task automatic step(input logic v0, input logic [A_W-1:0] a0, input logic [B_W-1:0] b0,
                        input logic v1, input logic [A_W-1:0] a1, input logic [B_W-1:0] b1,
                        input logic r0, input logic r1,
                        input bit chk, input logic [1:0] exp_rdy,
                        input logic [SUM_W-1:0] s0, input logic [SUM_W-1:0] s1,
                        output logic acc0, output logic acc1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1;
        if (chk) check("req_ready", {62'd0, req1_ready, req0_ready}, {62'd0, exp_rdy});
        if (req0_ready && req1_ready) check("ready_excl", 64'd1, 64'd0);
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        if (acc0) exp_q.push_back('{owner: 1'b0, sum: s0});
        if (acc1) exp_q.push_back('{owner: 1'b1, sum: s1});
    endtask

    task automatic idle(input logic r0, input logic r1);
        logic x0, x1;
        step(1'b0, '0, '0, 1'b0, '0, '0, r0, r1, 1'b1, 2'b00, '0, '0, x0, x1);
    endtask

    // Monitor: compare every response handshake against the scoreboard.
    // Also check exclusivity, hold stability and the zero value on an idle sum.
    logic             hold0, hold1;
    logic [SUM_W-1:0] prev0, prev1;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold0 = 1'b0;
            hold1 = 1'b0;
        end else begin
            check("rsp_excl", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
            if (hold0) begin
                check("hold0_valid", {63'd0, rsp0_valid}, 64'd1);
                check("hold0_sum", {11'd0, rsp0_sum}, {11'd0, prev0});
            end
            if (hold1) begin
                check("hold1_valid", {63'd0, rsp1_valid}, 64'd1);
                check("hold1_sum", {11'd0, rsp1_sum}, {11'd0, prev1});
            end
            if (!rsp0_valid) check("idle0_sum", {11'd0, rsp0_sum}, 64'd0);
            if (!rsp1_valid) check("idle1_sum", {11'd0, rsp1_sum}, 64'd0);
            if (rsp0_valid && rsp0_ready) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL sb_rsp0: got unexpected response %h, expected none", rsp0_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_owner0", 64'd0, {63'd0, e.owner});
                    check("sb_sum0", {11'd0, rsp0_sum}, {11'd0, e.sum});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL sb_rsp1: got unexpected response %h, expected none", rsp1_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_owner1", 64'd1, {63'd0, e.owner});
                    check("sb_sum1", {11'd0, rsp1_sum}, {11'd0, e.sum});
                end
            end
            hold0 = rsp0_valid & ~rsp0_ready;
            hold1 = rsp1_valid & ~rsp1_ready;
            prev0 = rsp0_sum;
            prev1 = rsp1_sum;
        end
    end

    initial begin
        logic             x0, x1;
        logic             v0, v1, acc0, acc1;
        logic [A_W-1:0]   ra0, ra1;
        logic [B_W-1:0]   rb0, rb1;
        logic [63:0]      t64;
        int               wait_cnt;

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
        check("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
        check("rst_rsp0_sum", {11'd0, rsp0_sum}, 64'd0);
        check("rst_rsp1_sum", {11'd0, rsp1_sum}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;

        // 1: req0 alone, carry into bit 52
        step(1'b1, A_ONES, 35'd1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 2'b01,
             53'h10_0000_0000_0000, '0, x0, x1);
        idle(1'b1, 1'b1);
        check("t1_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
        check("t1_rsp0_sum", {11'd0, rsp0_sum}, {11'd0, 53'h10_0000_0000_0000});
        check("t1_busy", {63'd0, busy}, 64'd1);
        check("t1_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);

        // 2: req1 alone, both operands all ones
        step(1'b0, '0, '0, 1'b1, A_ONES, B_ONES, 1'b1, 1'b1, 1'b1, 2'b10,
             '0, 53'h10_0007_FFFF_FFFE, x0, x1);
        idle(1'b1, 1'b1);
        check("t2_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
        check("t2_rsp1_sum", {11'd0, rsp1_sum}, {11'd0, 53'h10_0007_FFFF_FFFE});

        // 3: continuous contention alternates 0,1,0,1
        step(1'b1, 52'd100, 35'd5, 1'b1, A_HI, B_HI, 1'b1, 1'b1, 1'b1, 2'b01, 53'd105, S_HI, x0, x1);
        step(1'b1, 52'd100, 35'd5, 1'b1, A_HI, B_HI, 1'b1, 1'b1, 1'b1, 2'b10, 53'd105, S_HI, x0, x1);
        step(1'b1, 52'd100, 35'd5, 1'b1, A_HI, B_HI, 1'b1, 1'b1, 1'b1, 2'b01, 53'd105, S_HI, x0, x1);
        step(1'b1, 52'd100, 35'd5, 1'b1, A_HI, B_HI, 1'b1, 1'b1, 1'b1, 2'b10, 53'd105, S_HI, x0, x1);
        idle(1'b1, 1'b1);

        // 4: req0 owner stalls for 3 cycles, then req1 gets the slot on the drain cycle
        step(1'b1, 52'd7, 35'd3, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 2'b01, 53'd10, '0, x0, x1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 52'd1, 35'd1, 1'b0, 1'b1, 1'b1, 2'b00, '0, 53'd2, x0, x1);
            check("t4_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
            check("t4_rsp0_sum", {11'd0, rsp0_sum}, 64'd10);
        end
        step(1'b0, '0, '0, 1'b1, 52'd1, 35'd1, 1'b1, 1'b1, 1'b1, 2'b10, '0, 53'd2, x0, x1);
        idle(1'b1, 1'b1);
        check("t4_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
        check("t4_rsp1_sum", {11'd0, rsp1_sum}, 64'd2);
        idle(1'b1, 1'b1);

        // 5: reset while rsp1 pending, then req0 wins the first contention
        step(1'b0, '0, '0, 1'b1, 52'd2, 35'd3, 1'b0, 1'b0, 1'b1, 2'b10, '0, 53'd5, x0, x1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        #1;
        check("t5_pre_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
        check("t5_rst_rsp1_sum", {11'd0, rsp1_sum}, 64'd0);
        check("t5_rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 52'd100, 35'd5, 1'b1, A_HI, B_HI, 1'b1, 1'b1, 1'b1, 2'b01, 53'd105, S_HI, x0, x1);
        step(1'b1, 52'd100, 35'd5, 1'b1, A_HI, B_HI, 1'b1, 1'b1, 1'b1, 2'b10, 53'd105, S_HI, x0, x1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // 6: random traffic, operands held stable while waiting for ready
        v0 = 1'b0; v1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        ra0 = '0; ra1 = '0; rb0 = '0; rb1 = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!v0 || acc0) begin
                v0  = 1'($urandom_range(0, 1));
                t64 = {$urandom, $urandom};
                ra0 = t64[A_W-1:0];
                t64 = {$urandom, $urandom};
                rb0 = t64[B_W-1:0];
            end
            if (!v1 || acc1) begin
                v1  = 1'($urandom_range(0, 1));
                t64 = {$urandom, $urandom};
                ra1 = t64[A_W-1:0];
                t64 = {$urandom, $urandom};
                rb1 = t64[B_W-1:0];
            end
            step(v0, ra0, rb0, v1, ra1, rb1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 2'b00,
                 {1'b0, ra0} + {18'd0, rb0}, {1'b0, ra1} + {18'd0, rb1}, acc0, acc1);
        end

        // Drain whatever is left, bounded.
        wait_cnt = 0;
        do begin
            idle(1'b1, 1'b1);
            wait_cnt++;
        end while (exp_q.size() != 0 && wait_cnt < 10);
        idle(1'b1, 1'b1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
